// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction fetch queue: two-wide push from fetch, two oldest entries shown to decode.
// Optional same-cycle bypass on an empty queue when IFQ_BYPASS_EN is defined.

module ifq_lane #(
  parameter int W = 64
) (
  input  logic         sel_byp,
  input  logic         vld,
  input  logic [W-1:0] mem_e,
  input  logic [W-1:0] byp_e,
  output logic [W-1:0] out_e
);
  assign out_e = !vld ? '0 : (sel_byp ? byp_e : mem_e);
endmodule

module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_valid2,
  input  logic [31:0]   in_pc1,
  input  logic [31:0]   in_inst1,
  input  logic [31:0]   in_pc2,
  input  logic [31:0]   in_inst2,
  output logic          in_ready,
  output logic          out_valid1,
  output logic          out_valid2,
  output logic [31:0]   out_pc1,
  output logic [31:0]   out_inst1,
  output logic [31:0]   out_pc2,
  output logic [31:0]   out_inst2,
  input  logic [1:0]    issue_cnt,
  output logic [AW:0]   count
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  ifq_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  ifq_entry_t [NUM_LANES-1:0] in_e, wr_e, out_e;
  logic [NUM_LANES-1:0]       wr_en, out_vld, byp_vld;
  logic [NUM_LANES-1:0][AW-1:0] wr_addr, rd_addr;

  logic        push, byp;
  logic [1:0]  iss_c, n_in, popped, skip, n_wr, n_rd;
  logic [AW:0] avail;

  assign in_e[0] = '{pc: in_pc1, inst: in_inst1};
  assign in_e[1] = '{pc: in_pc2, inst: in_inst2};
  assign byp_vld = {in_valid && in_valid2, in_valid};

  assign in_ready = (count <= (AW+1)'(DEPTH - 2));
  assign push     = in_valid && in_ready && !flush;
  assign n_in     = !push ? 2'd0 : (in_valid2 ? 2'd2 : 2'd1);
  assign iss_c    = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;

`ifdef IFQ_BYPASS_EN
  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  // On bypass, decode pops straight off the incoming pair; those entries are never stored.
  assign avail  = byp ? (AW+1)'(n_in) : count;
  assign popped = (avail < (AW+1)'(iss_c)) ? avail[1:0] : iss_c;
  assign skip   = byp ? popped : 2'd0;
  assign n_wr   = n_in - skip;
  assign n_rd   = popped - skip;

  assign wr_e[0] = skip[0] ? in_e[1] : in_e[0];
  assign wr_e[1] = in_e[1];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign wr_addr[k] = wr_ptr[AW-1:0] + AW'(k);
    assign rd_addr[k] = rd_ptr[AW-1:0] + AW'(k);
    assign wr_en[k]   = n_wr > 2'(k);
    assign out_vld[k] = byp ? byp_vld[k] : (count > (AW+1)'(k));
    ifq_lane #(.W(VEC_W)) u_lane (
      .sel_byp (byp),
      .vld     (out_vld[k]),
      .mem_e   (mem[rd_addr[k]]),
      .byp_e   (in_e[k]),
      .out_e   (out_e[k])
    );
  end

  assign out_valid1 = out_vld[0];
  assign out_valid2 = out_vld[1];
  assign out_pc1    = out_e[0].pc;
  assign out_inst1  = out_e[0].inst;
  assign out_pc2    = out_e[1].pc;
  assign out_inst2  = out_e[1].inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (wr_en[k]) mem[wr_addr[k]] <= wr_e[k];
      wr_ptr <= wr_ptr + (AW+1)'(n_wr);
      rd_ptr <= rd_ptr + (AW+1)'(n_rd);
      count  <= count + (AW+1)'(n_wr) - (AW+1)'(n_rd);
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model.
// Model follows IFQ_BYPASS_EN the same way the design does.

module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_valid2;
  logic [31:0] in_pc1, in_inst1, in_pc2, in_inst2;
  logic        in_ready, out_valid1, out_valid2;
  logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;
  logic [1:0]  issue_cnt;
  logic [AW:0] count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_valid2(in_valid2),
    .in_pc1(in_pc1), .in_inst1(in_inst1), .in_pc2(in_pc2), .in_inst2(in_inst2),
    .in_ready(in_ready), .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_inst1(out_inst1), .out_pc2(out_pc2), .out_inst2(out_inst2),
    .issue_cnt(issue_cnt), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive, check at negedge, advance model at posedge.
  task automatic step(input logic iv, input logic iv2, input logic [31:0] p1, input logic [31:0] i1,
                      input logic [31:0] p2, input logic [31:0] i2, input logic [1:0] iss, input logic fl);
    int sz, n;
    logic byp, rdy, v1, v2;
    logic [63:0] e1, e2;
    logic [63:0] lst[$];
    flush = fl; in_valid = iv; in_valid2 = iv2;
    in_pc1 = p1; in_inst1 = i1; in_pc2 = p2; in_inst2 = i2; issue_cnt = iss;
    @(negedge clk);
    sz  = q.size();
    byp = BYP && sz == 0 && !fl;
    rdy = (DEPTH - sz) >= 2;
    if (byp) begin
      v1 = iv; v2 = iv && iv2; e1 = {p1, i1}; e2 = {p2, i2};
    end else begin
      v1 = sz >= 1; v2 = sz >= 2;
      e1 = v1 ? q[0] : 64'h0;
      e2 = v2 ? q[1] : 64'h0;
    end
    if (!v1) e1 = 64'h0;
    if (!v2) e2 = 64'h0;
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("valid1", 64'(out_valid1), 64'(v1));
    chk("valid2", 64'(out_valid2), 64'(v2));
    chk("slot1", {out_pc1, out_inst1}, e1);
    chk("slot2", {out_pc2, out_inst2}, e2);
    @(posedge clk);
    n = (iss == 2'd3) ? 2 : int'(iss);
    if (fl) q.delete();
    else begin
      if (iv && rdy) begin
        lst.push_back({p1, i1});
        if (iv2) lst.push_back({p2, i2});
      end
      if (byp) begin
        while (n > 0 && lst.size() > 0) begin void'(lst.pop_front()); n--; end
      end else begin
        while (n > 0 && q.size() > 0) begin void'(q.pop_front()); n--; end
      end
      foreach (lst[i]) q.push_back(lst[i]);
    end
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'h0);
    chk({tag, "_ready"}, 64'(in_ready), 64'h1);
    chk({tag, "_valids"}, {62'h0, out_valid2, out_valid1}, 64'h0);
    chk({tag, "_data"}, {out_pc1 | out_pc2, out_inst1 | out_inst2}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_pc1 = '0; in_inst1 = '0; in_pc2 = '0; in_inst2 = '0; issue_cnt = '0;
    #2;
    chk_reset_state("reset");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // 1: first pair visible next cycle
    step(1, 1, 32'h0, 32'h00000820, 32'h4, 32'hC4200000, 2'd0, 0);
    chk("t1_count", 64'(count), 64'd2);
    chk("t1_pc1", 64'(out_pc1), 64'h0);
    chk("t1_pc2", 64'(out_pc2), 64'h4);
    chk("t1_valids", {62'h0, out_valid2, out_valid1}, 64'h3);

    // 2: fill to full, 5th push dropped
    for (int i = 1; i < 4; i++)
      step(1, 1, 32'(8 * i), $urandom, 32'(8 * i + 4), $urandom, 2'd0, 0);
    chk("t2_full", 64'(count), 64'd8);
    chk("t2_ready", 64'(in_ready), 64'h0);
    step(1, 1, 32'h100, 32'hAAAA, 32'h104, 32'hBBBB, 2'd0, 0);
    chk("t2_drop", 64'(count), 64'd8);

    // 3: pop while full with held push, then retry accepted
    step(1, 1, 32'h100, 32'hAAAA, 32'h104, 32'hBBBB, 2'd2, 0);
    chk("t3_count", 64'(count), 64'd6);
    chk("t3_ready", 64'(in_ready), 64'h1);
    step(1, 1, 32'h100, 32'hAAAA, 32'h104, 32'hBBBB, 2'd0, 0);
    chk("t3_accept", 64'(count), 64'd8);

    // 4: drain to 1, then over-request
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 2'd2, 0);
    step(0, 0, 0, 0, 0, 0, 2'd1, 0);
    chk("t4_one", 64'(count), 64'd1);
    step(0, 0, 0, 0, 0, 0, 2'd3, 0);
    chk("t4_empty", 64'(count), 64'd0);
    chk("t4_valid1", 64'(out_valid1), 64'h0);
    step(0, 0, 0, 0, 0, 0, 2'd2, 0);

    // 5: wr_ptr is at 2; five singles bring it to 7, then a straddling pair
    for (int i = 0; i < 5; i++) step(1, 0, 32'h200 + 32'(4 * i), $urandom, 0, 0, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0, 2'd2, 0);
    step(0, 0, 0, 0, 0, 0, 2'd2, 0);
    step(0, 0, 0, 0, 0, 0, 2'd1, 0);
    step(1, 1, 32'h300, 32'h11, 32'h304, 32'h22, 2'd0, 0);
    chk("t5_pc1", 64'(out_pc1), 64'h300);
    chk("t5_pc2", 64'(out_pc2), 64'h304);
    step(0, 0, 0, 0, 0, 0, 2'd1, 0);
    chk("t5_wrap", {out_pc1, out_inst1}, {32'h304, 32'h22});
    step(0, 0, 0, 0, 0, 0, 2'd1, 0);

    // 6: flush at count=5 with push and pop
    step(1, 1, 32'h400, 1, 32'h404, 2, 2'd0, 0);
    step(1, 1, 32'h408, 3, 32'h40C, 4, 2'd0, 0);
    step(1, 0, 32'h410, 5, 0, 0, 2'd0, 0);
    chk("t6_five", 64'(count), 64'd5);
    step(1, 1, 32'h500, 6, 32'h504, 7, 2'd2, 1);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valids", {62'h0, out_valid2, out_valid1}, 64'h0);

`ifdef IFQ_BYPASS_EN
    flush = 0; in_valid = 1; in_valid2 = 1; issue_cnt = 2'd2;
    in_pc1 = 32'h8; in_inst1 = 32'h1234; in_pc2 = 32'hC; in_inst2 = 32'h5678;
    @(negedge clk);
    chk("byp_pc1", 64'(out_pc1), 64'h8);
    @(posedge clk); #1;
    in_valid = 0; in_valid2 = 0; issue_cnt = 2'd0;
    chk("byp_count", 64'(count), 64'h0);
`endif

    // random phases: fill-biased, balanced, drain-biased; one async reset mid-run
    for (int i = 0; i < 3000; i++) begin
      int mode;
      logic [1:0] iss;
      mode = (i / 200) % 3;
      if (i == 1500) begin
        rst = 1'b1; #1;
        chk_reset_state("midrst");
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
      end
      case (mode)
        0:       iss = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
        1:       iss = 2'($urandom_range(0, 3));
        default: iss = 2'($urandom_range(1, 3));
      endcase
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
           iss, ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
